// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - opcode classes, NOP codes, source/reg-enable codes and FSM states for instr_decode_pipe
package instr_decode_pkg;

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_LOAD = 3'd0,
    CLS_MOV  = 3'd1,
    CLS_ALU  = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_JCC  = 3'd4
  } op_class_e;

  // Opcode class prefixes: mov on ir[7:6], ALU on ir[7:5], jumps on ir[7:4].
  localparam logic [1:0] OPC_MOV = 2'b10;
  localparam logic [2:0] OPC_ALU = 3'b110;
  localparam logic [3:0] OPC_JMP = 4'b1110;
  localparam logic [3:0] OPC_JCC = 4'b1111;

  // Instructions reported on nop_hit[0..3].
  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  // source_sel codes that are not a plain register number.
  localparam logic [3:0] SRC_ALU  = 4'h0;
  localparam logic [3:0] SRC_IMM  = 4'h8;
  localparam logic [3:0] SRC_SELF = 4'h9;
  localparam logic [3:0] SRC_CLR  = 4'hA;

  // reg_en bit positions that do not match the register number.
  localparam int unsigned REN_ALU = 4;
  localparam int unsigned REN_R6  = 6;
  localparam int unsigned REN_R7  = 7;
  localparam int unsigned REN_R4  = 8;
  localparam logic [8:0]  REG_EN_ALL = 9'h1FF;

  function automatic op_class_e classify(input logic [7:0] instr);
    op_class_e cls;
    cls = CLS_LOAD;
    if (instr[7:6] == OPC_MOV) cls = CLS_MOV;
    else if (instr[7:5] == OPC_ALU) cls = CLS_ALU;
    else if (instr[7:4] == OPC_JMP) cls = CLS_JMP;
    else if (instr[7:4] == OPC_JCC) cls = CLS_JCC;
    return cls;
  endfunction

  // Destination register to write-enable mapping shared by load and mov.
  function automatic logic [8:0] dst_reg_en(input logic [2:0] dst);
    logic [8:0] en;
    en = '0;
    case (dst)
      3'd4: en[REN_R4] = 1'b1;
      3'd7: begin
        en[REN_R7] = 1'b1;
        en[REN_R6] = 1'b1;
      end
      default: en[dst] = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - power-of-two instruction FIFO with flush and full-time push/pop
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointers, count and storage; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - buffered instruction decoder; DECODE_NOP_CNT_EN adds the nop_count port
module instr_decode_pipe
  import instr_decode_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned NOP_CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [7:0] in_instr,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] ir,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       jump,
  output logic       cond_jump,
  output logic [3:0] jump_addr,
  output logic [3:0] nop_hit
`ifdef DECODE_NOP_CNT_EN
  ,
  output logic [NOP_CNT_W-1:0] nop_count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_decode_pipe: DEPTH must be a power of two >= 2");
  end
  if (NOP_CNT_W < 1) begin : g_bad_nop_cnt_w
    $error("instr_decode_pipe: NOP_CNT_W must be >= 1");
  end

  state_e     state_q, state_d;
  logic       valid_q, valid_d;
  logic [7:0] ir_q, ir_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       load;

  op_class_e  dec_class;
  logic [2:0] ld_dst, mv_dst, mv_src;
  logic [8:0] dec_reg_en;
  logic [3:0] dec_src, dec_jaddr, dec_nop;
  logic       dec_i, dec_x, dec_y, dec_jump, dec_cjump;

  // Decode register refills whenever it is empty or its content is being taken.
  assign load      = !fifo_empty && (!valid_q || out_ready) && !flush;
  assign fifo_pop  = load;
  assign fifo_push = in_valid && in_ready && !flush;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (in_instr),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_CLR;
    else          state_q <= state_d;
  end

  // FSM next state and fetch-side ready; intake is closed in CLR and FLUSH.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_CLR:   state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN: begin
        state_d  = ST_RUN;
        in_ready = !fifo_full;
      end
      default:  state_d = ST_CLR;
    endcase
    if (flush) state_d = ST_FLUSH;
  end

  // Decode register next state; flush drops the held instruction.
  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ir_d    = fifo_rdata;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Decode register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
    end
  end

  assign dec_class = classify(ir_q);
  assign ld_dst    = ir_q[6:4];
  assign mv_dst    = ir_q[5:3];
  assign mv_src    = ir_q[2:0];

  // Raw field decode of the held instruction, before valid gating.
  always_comb begin
    dec_reg_en = '0;
    dec_src    = SRC_ALU;
    dec_i      = 1'b0;
    dec_x      = 1'b0;
    dec_y      = 1'b0;
    dec_jump   = 1'b0;
    dec_cjump  = 1'b0;
    dec_jaddr  = '0;
    case (dec_class)
      CLS_LOAD: begin
        dec_reg_en = dst_reg_en(ld_dst);
        dec_src    = SRC_IMM;
        dec_i      = (ld_dst == 3'd7);
        dec_x      = (ld_dst == 3'd1);
        dec_y      = (ld_dst == 3'd3);
      end
      CLS_MOV: begin
        dec_reg_en = dst_reg_en(mv_dst);
        if (mv_src == 3'd7) dec_reg_en[REN_R6] = 1'b1;
        if (mv_src != mv_dst)    dec_src = {1'b0, mv_src};
        else if (mv_src == 3'd4) dec_src = 4'd4;
        else                     dec_src = SRC_SELF;
        dec_i = (mv_dst == 3'd7) || ((mv_src == 3'd7) && (mv_dst != 3'd6));
      end
      CLS_ALU: begin
        dec_reg_en[REN_ALU] = 1'b1;
        dec_x = ir_q[4];
        dec_y = ir_q[3];
      end
      CLS_JMP: begin
        dec_jump  = 1'b1;
        dec_jaddr = ir_q[3:0];
      end
      CLS_JCC: begin
        dec_cjump = 1'b1;
        dec_jaddr = ir_q[3:0];
      end
      default: dec_reg_en = '0;
    endcase
  end

  assign dec_nop = {ir_q == NOP_DF, ir_q == NOP_D8, ir_q == NOP_CF, ir_q == NOP_C8};

  // Output gating by out_valid, with the CLR-state register-clear pattern on top.
  always_comb begin
    out_valid  = valid_q;
    ir         = ir_q;
    reg_en     = '0;
    source_sel = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jump       = 1'b0;
    cond_jump  = 1'b0;
    jump_addr  = '0;
    nop_hit    = '0;
    if (valid_q) begin
      reg_en     = dec_reg_en;
      source_sel = dec_src;
      i_sel      = dec_i;
      x_sel      = dec_x;
      y_sel      = dec_y;
      jump       = dec_jump;
      cond_jump  = dec_cjump;
      jump_addr  = dec_jaddr;
      nop_hit    = dec_nop;
    end
    if (state_q == ST_CLR) begin
      reg_en     = REG_EN_ALL;
      source_sel = SRC_CLR;
    end
  end

`ifdef DECODE_NOP_CNT_EN
  logic [NOP_CNT_W-1:0] nop_cnt_q, nop_cnt_d;

  // Count consumed NOP decodes, saturating; flush leaves the count alone.
  always_comb begin
    nop_cnt_d = nop_cnt_q;
    if (valid_q && out_ready && (|dec_nop) && (nop_cnt_q != {NOP_CNT_W{1'b1}}))
      nop_cnt_d = nop_cnt_q + 1'b1;
  end

  // NOP counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nop_cnt_q <= '0;
    else          nop_cnt_q <= nop_cnt_d;
  end

  assign nop_count = nop_cnt_q;
`endif

endmodule
